ledg_blink: RTL and testbench
=============================

LEDG_BLINK -- requirements
Module: ledg_blink

Interface
REQ-001 Parameter BITS, default 32: address/data bus width.
REQ-002 Parameter BASE, default 32'hF0000000: base address of the register block; word aligned.
REQ-003 Parameter NLEDS, default 8: LED channel count, 1..BITS.
REQ-004 Parameter PER_W, default 24: blink period counter width, 1..BITS.
REQ-005 CLK  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 ABUS  input  BITS  byte address from the processor.
REQ-008 DBUS  inout  BITS  shared data bus; driven only during a selected read, else high-Z.
REQ-009 WE  input  1  1 = write cycle, 0 = read cycle.
REQ-010 ledOut  output  NLEDS  registered LED drive, bit i = channel i.

Function
REQ-011 Register map: BASE+0x0 DATA (RW), +0x4 MASK (RW), +0x8 PERIOD (RW), +0xC COUNT (RO), +0x10 TOGGLE (WO).
REQ-012 Select SHALL be an exact full-width compare of ABUS to each offset; other addresses SHALL not be decoded.
REQ-013 Write to DATA/MASK SHALL load DBUS[NLEDS-1:0] on the same edge; upper bits ignored.
REQ-014 Write to TOGGLE SHALL set DATA <= DATA XOR DBUS[NLEDS-1:0]; TOGGLE reads return 0.
REQ-015 Write to PERIOD SHALL load PERIOD <= DBUS[PER_W-1:0], load COUNT <= same value, and set phase <= 1, all on the same edge.
REQ-016 When PERIOD != 0 and no PERIOD write: COUNT SHALL decrement by 1 each cycle; when COUNT == 0, COUNT SHALL reload PERIOD and phase SHALL toggle (half-period = PERIOD+1 cycles).
REQ-017 When PERIOD == 0: COUNT SHALL hold 0 and phase SHALL hold 1 (blinking disabled, steady on).
REQ-018 PERIOD write coinciding with terminal count SHALL take priority; no toggle that cycle.
REQ-019 ledOut[i] SHALL be registered: ledOut[i] <= DATA_next[i] & (~MASK_next[i] | phase_next); one-cycle latency from any write or phase change.
REQ-020 Reads (WE=0, address selected) SHALL drive DBUS combinationally with the register zero-extended to BITS; COUNT read returns the value held before the current edge.
REQ-021 Writes to COUNT SHALL be ignored.

Reset
REQ-022 On reset low, asynchronously: DATA=0, MASK=0, PERIOD=0, COUNT=0, phase=1, ledOut=0.
REQ-023 Reset mid-blink SHALL abort the period with no residual toggle after release; first edge after release obeys REQ-016/017.
REQ-024 DBUS SHALL be high-Z during reset unless a read is selected.

Structure
REQ-025 Register offsets (0x0, 0x4, 0x8, 0xC, 0x10) SHALL be constants in the shared peripheral package with the other I/O offsets.
REQ-026 Period counter plus phase flop SHALL be sub-module ledg_blink_timer (inputs load, loadVal, CLK, reset; outputs count, phase).
REQ-027 Decode, register file, read mux and ledOut SHALL stay in ledg_blink.

Verification
REQ-028 Reset low, release; write DATA=0xA5 -> ledOut=0xA5 one cycle later; read DATA returns 0x000000A5.
REQ-029 DATA=0xFF, MASK=0x0F, PERIOD=3 -> ledOut low nibble alternates every 4 cycles between 0x0F and 0x00, high nibble steady 0xF.
REQ-030 Write TOGGLE=0x81 with DATA=0x80 -> DATA=0x01; TOGGLE read returns 0.
REQ-031 Write PERIOD=5 exactly when COUNT=0 -> COUNT=5, phase=1, no toggle that cycle.
REQ-032 Assert reset while PERIOD=2 mid-blink -> all registers 0, phase=1, ledOut=0 immediately, no toggle after release.
REQ-033 Read BASE+0x14 and write BASE+0xC -> DBUS high-Z, no register change.

Source files
------------

// File: rtl/ledg_blink_pkg.sv
// ledg_blink_pkg: shared peripheral constants for the processor I/O space.
// Holds the byte offsets of every register in the LED blink block and the
// register-select enum that the decoder produces.
package ledg_blink_pkg;

  // LED blink register offsets, relative to the block base address.
  localparam logic [31:0] OFS_DATA   = 32'h0000_0000;
  localparam logic [31:0] OFS_MASK   = 32'h0000_0004;
  localparam logic [31:0] OFS_PERIOD = 32'h0000_0008;
  localparam logic [31:0] OFS_COUNT  = 32'h0000_000C;
  localparam logic [31:0] OFS_TOGGLE = 32'h0000_0010;

  typedef enum logic [2:0] {
    RegNone,
    RegData,
    RegMask,
    RegPeriod,
    RegCount,
    RegToggle
  } reg_sel_e;

endpackage

// File: rtl/ledg_blink_timer.sv
// ledg_blink_timer: blink period down-counter plus phase flop.
// Ports:
//   CLK        clock, rising edge
//   reset      asynchronous active-low reset (count=0, phase=1)
//   load       PERIOD register write this cycle; wins over everything else
//   loadVal    value loaded into count on a load
//   period     current PERIOD register, reload value at terminal count
//   count      registered counter value
//   phase      registered blink phase (1 = LEDs on)
//   phase_next value phase takes on the next edge, for the registered LED drive
module ledg_blink_timer #(
  parameter int unsigned PER_W = 24
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             load,
  input  logic [PER_W-1:0] loadVal,
  input  logic [PER_W-1:0] period,
  output logic [PER_W-1:0] count,
  output logic             phase,
  output logic             phase_next
);

  logic [PER_W-1:0] count_q, count_d;
  logic             phase_q, phase_d;

  always_comb begin
    count_d = count_q;
    phase_d = phase_q;
    if (load) begin
      // A PERIOD write restarts the half-period in the on phase, even at terminal count.
      count_d = loadVal;
      phase_d = 1'b1;
    end else if (period == '0) begin
      count_d = '0;
      phase_d = 1'b1;
    end else if (count_q == '0) begin
      count_d = period;
      phase_d = ~phase_q;
    end else begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      phase_q <= 1'b1;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
    end
  end

  assign count      = count_q;
  assign phase      = phase_q;
  assign phase_next = phase_d;

endmodule

// File: rtl/ledg_blink.sv
// ledg_blink: memory-mapped LED driver with per-channel blink masking.
// Registers at BASE: +0x0 DATA, +0x4 MASK, +0x8 PERIOD, +0xC COUNT (RO), +0x10 TOGGLE (WO).
// Ports:
//   CLK     clock, rising edge
//   reset   asynchronous active-low reset
//   ABUS    byte address from the processor
//   DBUS    shared data bus, driven only on a selected read, else high-Z
//   WE      1 = write cycle, 0 = read cycle
//   ledOut  registered LED drive, bit i = channel i
module ledg_blink
  import ledg_blink_pkg::*;
#(
  parameter int unsigned     BITS  = 32,
  parameter logic [BITS-1:0] BASE  = BITS'(32'hF000_0000),
  parameter int unsigned     NLEDS = 8,
  parameter int unsigned     PER_W = 24
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [BITS-1:0]  ABUS,
  inout  wire  [BITS-1:0]  DBUS,
  input  logic             WE,
  output logic [NLEDS-1:0] ledOut
);

  localparam logic [BITS-1:0] ADDR_DATA   = BASE + BITS'(OFS_DATA);
  localparam logic [BITS-1:0] ADDR_MASK   = BASE + BITS'(OFS_MASK);
  localparam logic [BITS-1:0] ADDR_PERIOD = BASE + BITS'(OFS_PERIOD);
  localparam logic [BITS-1:0] ADDR_COUNT  = BASE + BITS'(OFS_COUNT);
  localparam logic [BITS-1:0] ADDR_TOGGLE = BASE + BITS'(OFS_TOGGLE);

  reg_sel_e         sel;
  logic [NLEDS-1:0] data_q, data_d;
  logic [NLEDS-1:0] mask_q, mask_d;
  logic [PER_W-1:0] period_q, period_d;
  logic             period_load;
  logic [NLEDS-1:0] led_d;
  logic [PER_W-1:0] count;
  logic             phase;
  logic             phase_next;
  logic [BITS-1:0]  rdata;

  // Exact full-width compare; aliases and misaligned addresses select nothing.
  always_comb begin
    sel = RegNone;
    if      (ABUS == ADDR_DATA)   sel = RegData;
    else if (ABUS == ADDR_MASK)   sel = RegMask;
    else if (ABUS == ADDR_PERIOD) sel = RegPeriod;
    else if (ABUS == ADDR_COUNT)  sel = RegCount;
    else if (ABUS == ADDR_TOGGLE) sel = RegToggle;
  end

  always_comb begin
    data_d      = data_q;
    mask_d      = mask_q;
    period_d    = period_q;
    period_load = 1'b0;
    if (WE) begin
      case (sel)
        RegData:   data_d = DBUS[NLEDS-1:0];
        RegMask:   mask_d = DBUS[NLEDS-1:0];
        RegToggle: data_d = data_q ^ DBUS[NLEDS-1:0];
        RegPeriod: begin
          period_d    = DBUS[PER_W-1:0];
          period_load = 1'b1;
        end
        default: ;  // COUNT is read-only
      endcase
    end
    // Built from next-state values so the LEDs follow a write or phase flip one cycle later.
    led_d = data_d & (~mask_d | {NLEDS{phase_next}});
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      data_q   <= '0;
      mask_q   <= '0;
      period_q <= '0;
      ledOut   <= '0;
    end else begin
      data_q   <= data_d;
      mask_q   <= mask_d;
      period_q <= period_d;
      ledOut   <= led_d;
    end
  end

  ledg_blink_timer #(
    .PER_W(PER_W)
  ) u_timer (
    .CLK       (CLK),
    .reset     (reset),
    .load      (period_load),
    .loadVal   (period_d),
    .period    (period_q),
    .count     (count),
    .phase     (phase),
    .phase_next(phase_next)
  );

  always_comb begin
    rdata = '0;
    case (sel)
      RegData:   rdata[NLEDS-1:0] = data_q;
      RegMask:   rdata[NLEDS-1:0] = mask_q;
      RegPeriod: rdata[PER_W-1:0] = period_q;
      RegCount:  rdata[PER_W-1:0] = count;
      default:   rdata = '0;  // TOGGLE reads as zero
    endcase
  end

  assign DBUS = (!WE && (sel != RegNone)) ? rdata : {BITS{1'bz}};

endmodule

// File: tb/tb_ledg_blink.sv
// tb_ledg_blink: directed scoreboard bench for ledg_blink.
// Stimulus pushes expected LED/bus values; a negedge monitor pops and compares.
module tb_ledg_blink;

  localparam logic [31:0] BASE     = 32'hF000_0000;
  localparam logic [31:0] A_DATA   = BASE + 32'h00;
  localparam logic [31:0] A_MASK   = BASE + 32'h04;
  localparam logic [31:0] A_PERIOD = BASE + 32'h08;
  localparam logic [31:0] A_COUNT  = BASE + 32'h0C;
  localparam logic [31:0] A_TOGGLE = BASE + 32'h10;
  localparam logic [31:0] A_IDLE   = BASE + 32'h100;
  // Released bus floats to the pull-up value.
  localparam logic [31:0] ZBUS     = 32'hFFFF_FFFF;

  logic        CLK;
  logic        reset;
  logic [31:0] ABUS;
  logic        WE;
  logic [7:0]  ledOut;
  wire  [31:0] DBUS;
  logic [31:0] tb_dq;
  logic        tb_drv;

  assign DBUS = tb_drv ? tb_dq : 32'bz;
  pullup pu_dbus (DBUS);

  ledg_blink dut (
    .CLK   (CLK),
    .reset (reset),
    .ABUS  (ABUS),
    .DBUS  (DBUS),
    .WE    (WE),
    .ledOut(ledOut)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    bit          is_bus;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input bit is_bus, input logic [31:0] exp);
    exp_t e;
    e.name   = name;
    e.is_bus = is_bus;
    e.exp    = exp;
    sb.push_back(e);
  endtask

  // Let the monitor sample at negedge, then resume just after the next rising edge.
  task automatic step();
    @(negedge CLK);
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    ABUS   = a;
    WE     = 1'b1;
    tb_dq  = d;
    tb_drv = 1'b1;
    @(posedge CLK);
    #1;
    WE     = 1'b0;
    tb_drv = 1'b0;
    ABUS   = A_IDLE;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    ABUS = a;
    WE   = 1'b0;
    chk(name, 1'b1, exp);
    step();
    ABUS = A_IDLE;
  endtask

  always @(negedge CLK) begin
    while (sb.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e   = sb.pop_front();
      act = e.is_bus ? DBUS : {24'b0, ledOut};
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h want %h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset  = 1'b0;
    WE     = 1'b0;
    ABUS   = A_IDLE;
    tb_drv = 1'b0;
    tb_dq  = '0;
    @(posedge CLK);
    #1;

    // Reset state.
    chk("rst_led", 1'b0, 32'h0);
    chk("rst_bus_z", 1'b1, ZBUS);
    step();
    rd_chk("rst_rd_data", A_DATA, 32'h0);
    reset = 1'b1;
    chk("idle_led", 1'b0, 32'h0);
    step();

    // DATA write, one-cycle LED latency, readback.
    wr(A_DATA, 32'h0000_00A5);
    chk("wr_data_led", 1'b0, 32'hA5);
    rd_chk("rd_data", A_DATA, 32'h0000_00A5);
    wr(A_DATA, 32'hFFFF_FF3C);
    rd_chk("data_upper_ignored", A_DATA, 32'h0000_003C);

    // TOGGLE.
    wr(A_DATA, 32'h80);
    wr(A_TOGGLE, 32'h81);
    chk("toggle_led", 1'b0, 32'h01);
    rd_chk("toggle_data", A_DATA, 32'h01);
    rd_chk("toggle_rd_zero", A_TOGGLE, 32'h0);

    // Undecoded addresses and read-only COUNT.
    rd_chk("unmapped_rd_z", BASE + 32'h14, ZBUS);
    wr(A_COUNT, 32'h55);
    rd_chk("count_wr_ignored", A_COUNT, 32'h0);
    wr(BASE + 32'h14, 32'hFF);
    wr(32'h0000_0000, 32'hFF);
    wr(BASE + 32'h1, 32'hFF);
    rd_chk("alias_data", A_DATA, 32'h01);
    chk("alias_led", 1'b0, 32'h01);
    rd_chk("alias_mask", A_MASK, 32'h0);

    // Blink: low nibble masked, half-period 4 cycles.
    wr(A_DATA, 32'hFF);
    wr(A_MASK, 32'h0F);
    wr(A_PERIOD, 32'h8000_0003);
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("blink3_%0d", k), 1'b0, (((k / 4) % 2) == 0) ? 32'hFF : 32'hF0);
      step();
    end
    rd_chk("blink3_count", A_COUNT, 32'h2);
    rd_chk("blink3_period", A_PERIOD, 32'h3);

    // COUNT is now 0 with phase on: PERIOD write must win, no toggle.
    wr(A_PERIOD, 32'h5);
    chk("term_load_led", 1'b0, 32'hFF);
    rd_chk("term_load_count", A_COUNT, 32'h5);
    for (int j = 0; j < 6; j++) begin
      chk($sformatf("blink5_%0d", j), 1'b0, (j < 5) ? 32'hFF : 32'hF0);
      step();
    end

    // Reset mid-blink.
    wr(A_PERIOD, 32'h2);
    chk("p2_led", 1'b0, 32'hFF);
    step();
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_led", 1'b0, 32'h0);
    chk("midrst_bus_z", 1'b1, ZBUS);
    step();
    rd_chk("midrst_data", A_DATA, 32'h0);
    rd_chk("midrst_mask", A_MASK, 32'h0);
    rd_chk("midrst_period", A_PERIOD, 32'h0);
    rd_chk("midrst_count", A_COUNT, 32'h0);
    reset = 1'b1;
    chk("post_rst_led", 1'b0, 32'h0);
    step();
    // All channels masked: LEDs on only while phase holds 1.
    wr(A_DATA, 32'hFF);
    wr(A_MASK, 32'hFF);
    for (int j = 0; j < 6; j++) begin
      chk($sformatf("steady_%0d", j), 1'b0, 32'hFF);
      step();
    end
    rd_chk("steady_count", A_COUNT, 32'h0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge CLK);
    #1;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
